// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding instruction
// memory handshake and the IF/ID pipeline register. Handles hazard-unit
// stalls, branch/jump redirects from ID and wrong-path flushing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_if_write_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc_plus4_id_o,
  output logic [31:0] instr_id_o,
  output logic        valid_id_o
);

  // IDLE: one cycle after reset; REQ: request outstanding at pc;
  // HOLD: response captured in buf while ID is stalled;
  // DROP: waiting out a wrong-path response before fetching pend_pc.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic        unused_target_lsbs;

  // Targets are word aligned; the two low bits are dropped on purpose.
  assign target_aligned     = {redirect_target_i[31:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target_i[1:0];
  assign pc_plus4           = pc_q + 32'd4;  // wraps modulo 2^32

  assign imem_req_o    = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr_o   = pc_q;
  assign pc_id_o       = pc_id_q;
  assign pc_plus4_id_o = pc_plus4_id_q;
  assign instr_id_o    = instr_id_q;
  assign valid_id_o    = valid_id_q;

  // Next-state, PC and IF/ID update logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    buf_d         = buf_q;
    pc_id_d       = pc_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    instr_id_d    = instr_id_q;
    valid_id_d    = valid_id_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (redirect_i) begin
          // Wrong-path instruction in IF/ID is squashed regardless of stall.
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
          if (imem_ready_i) begin
            pc_d = target_aligned;
          end else begin
            pend_pc_d = target_aligned;
            state_d   = S_DROP;
          end
        end else if (imem_ready_i) begin
          if (pc_if_write_i) begin
            pc_id_d       = pc_q;
            pc_plus4_id_d = pc_plus4;
            instr_id_d    = imem_rdata_i;
            valid_id_d    = 1'b1;
            pc_d          = pc_plus4;
          end else begin
            buf_d   = imem_rdata_i;
            state_d = S_HOLD;
          end
        end else if (pc_if_write_i) begin
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_d       = target_aligned;
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
          state_d    = S_REQ;
        end else if (pc_if_write_i) begin
          pc_id_d       = pc_q;
          pc_plus4_id_d = pc_plus4;
          instr_id_d    = buf_q;
          valid_id_d    = 1'b1;
          pc_d          = pc_plus4;
          state_d       = S_REQ;
        end
      end

      S_DROP: begin
        // Latest redirect wins, including one arriving with the stale response.
        if (redirect_i) pend_pc_d = target_aligned;
        if (imem_ready_i) begin
          pc_d    = redirect_i ? target_aligned : pend_pc_q;
          state_d = S_REQ;
        end
        if (pc_if_write_i) begin
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      buf_q         <= '0;
      pc_id_q       <= '0;
      pc_plus4_id_q <= '0;
      instr_id_q    <= NOP_INSTR;
      valid_id_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      buf_q         <= buf_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      instr_id_q    <= instr_id_d;
      valid_id_q    <= valid_id_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w, redir, ready;
  logic [31:0] tgt, rdata;

  logic        req, valid, req_w, valid_w;
  logic [31:0] addr, pc_id, pc4, instr, addr_w, pc_id_w, pc4_w, instr_w;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if_write_i(w), .redirect_i(redir),
    .redirect_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .pc_id_o(pc_id),
    .pc_plus4_id_o(pc4), .instr_id_o(instr), .valid_id_o(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_if_write_i(w), .redirect_i(redir),
    .redirect_target_i(tgt), .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .pc_id_o(pc_id_w),
    .pc_plus4_id_o(pc4_w), .instr_id_o(instr_w), .valid_id_o(valid_w)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w_, input logic r_, input logic [31:0] t_, input logic rdy_);
    w     = w_;
    redir = r_;
    tgt   = t_;
    ready = rdy_;
    rdata = rdy_ ? mem_word(addr) : 32'hDEAD_BEEF;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic        redir;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[16];

  // Reference model: fetch progress tracked as flags and a one-entry buffer.
  logic        m_started, m_have_buf, m_dropping;
  logic [31:0] m_pc, m_buf, m_pend;
  logic        m_id_valid;
  logic [31:0] m_id_pc, m_id_pc4, m_id_instr;
  int          lat_left;

  task automatic model_reset();
    m_started  = 1'b0;
    m_have_buf = 1'b0;
    m_dropping = 1'b0;
    m_pc       = 32'h0;
    m_buf      = 32'h0;
    m_pend     = 32'h0;
    m_id_valid = 1'b0;
    m_id_pc    = 32'h0;
    m_id_pc4   = 32'h0;
    m_id_instr = 32'h0;
    lat_left   = int'($urandom_range(0, 3));
  endtask

  task automatic model_squash();
    m_id_valid = 1'b0;
    m_id_instr = 32'h0;
  endtask

  task automatic model_issue(input logic [31:0] word);
    m_id_pc    = m_pc;
    m_id_pc4   = m_pc + 32'd4;
    m_id_instr = word;
    m_id_valid = 1'b1;
    m_pc       = m_pc + 32'd4;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_have_buf) begin
      if (redir) begin
        m_have_buf = 1'b0;
        m_pc = t;
        model_squash();
      end else if (w) begin
        model_issue(m_buf);
        m_have_buf = 1'b0;
      end
    end else if (m_dropping) begin
      if (redir) m_pend = t;
      if (ready) begin
        m_dropping = 1'b0;
        m_pc = m_pend;
      end
      if (w) model_squash();
    end else begin
      if (redir) begin
        model_squash();
        if (ready) m_pc = t;
        else begin
          m_dropping = 1'b1;
          m_pend = t;
        end
      end else if (ready) begin
        if (w) model_issue(rdata);
        else begin
          m_buf = rdata;
          m_have_buf = 1'b1;
        end
      end else if (w) begin
        model_squash();
      end
    end
  endtask

  initial begin
    logic m_req;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 1'b0, 32'h000, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b1, 32'h000, mem_word(32'h000)};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h004, mem_word(32'h004)};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h008, 1'b1, 32'h004, mem_word(32'h004)};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h008, 1'b1, 32'h004, mem_word(32'h004)};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 1'b1, 32'h008, mem_word(32'h008)};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h00C, mem_word(32'h00C)};
    tbl[7]  = '{1'b1, 1'b1, 32'h40,  1'b1, 1'b1, 32'h040, 1'b0, 32'h00C, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h044, 1'b1, 32'h040, mem_word(32'h040)};
    tbl[9]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h044, 1'b0, 32'h040, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 32'h202, 1'b0, 1'b1, 32'h044, 1'b0, 32'h040, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h040, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200, mem_word(32'h200)};
    tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 32'h200, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 32'h200, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h204, mem_word(32'h204)};

    // Directed table: streaming, HOLD stall, redirects with and without DROP.
    do_reset();
    check("reset.req", req, 1'b0);
    check("reset.valid", valid, 1'b0);
    check("reset.instr", instr, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].w, tbl[i].redir, tbl[i].tgt, tbl[i].rdy);
      step();
      check($sformatf("row%0d.req", i), req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("row%0d.addr", i), addr, tbl[i].e_addr);
      check($sformatf("row%0d.valid", i), valid, tbl[i].e_valid);
      check($sformatf("row%0d.pc_id", i), pc_id, tbl[i].e_pc);
      check($sformatf("row%0d.pc4", i), pc4, (i == 0) ? 32'h0 : tbl[i].e_pc + 32'd4);
      check($sformatf("row%0d.instr", i), instr, tbl[i].e_instr);
    end

    // Slow memory: redirect during a wait at 0x20 goes through DROP.
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
    drive(1'b1, 1'b1, 32'h20, 1'b1); step();
    check("slow.addr20", addr, 32'h20);
    drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
    drive(1'b1, 1'b1, 32'h80, 1'b0); step();
    check("slow.drop_req", req, 1'b1);
    check("slow.drop_addr", addr, 32'h20);
    check("slow.drop_valid", valid, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
    check("slow.drop_addr2", addr, 32'h20);
    drive(1'b1, 1'b0, 32'h0, 1'b1);  step();
    check("slow.resume_addr", addr, 32'h80);
    check("slow.resume_valid", valid, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
    drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
    drive(1'b1, 1'b0, 32'h0, 1'b1);  step();
    check("slow.pc_id", pc_id, 32'h80);
    check("slow.valid", valid, 1'b1);
    check("slow.instr", instr, mem_word(32'h80));
    check("slow.next_addr", addr, 32'h84);

    // Asynchronous reset mid-wait, then restart from RESET_PC; PC wrap instance.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("areset.req", req, 1'b0);
    check("areset.valid", valid, 1'b0);
    check("areset.pc_id", pc_id, 32'h0);
    check("areset.pc4", pc4, 32'h0);
    check("areset.instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("areset.idle_req", req, 1'b0);
    step();
    check("areset.restart_addr", addr, 32'h0);
    check("wrap.first_addr", addr_w, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0, 1'b1); step();
    check("areset.pc_id", pc_id, 32'h0);
    check("areset.valid1", valid, 1'b1);
    check("wrap.pc_id", pc_id_w, 32'hFFFF_FFFC);
    check("wrap.pc4", pc4_w, 32'h0);
    check("wrap.second_addr", addr_w, 32'h0);
    check("wrap.valid", valid_w, 1'b1);

    // Randomized run with variable memory latency against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      m_req = m_started && !m_have_buf;
      check("rand.req", req, m_req);
      if (m_req) check("rand.addr", addr, m_pc);
      check("rand.valid", valid, m_id_valid);
      check("rand.pc_id", pc_id, m_id_pc);
      check("rand.pc4", pc4, m_id_pc4);
      check("rand.instr", instr, m_id_instr);
      w     = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      ready = m_req ? (lat_left == 0) : 1'($urandom_range(0, 1));
      rdata = (m_req && ready) ? mem_word(m_pc) : $urandom;
      if (m_req) begin
        if (ready) lat_left = int'($urandom_range(0, 3));
        else lat_left--;
      end
      model_step();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register, instruction-fetch handshake and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Sits directly upstream of the ID stage and consumes the hazard unit's PC/IF-write enable (PC_IFWrite) to hold PC and IF/ID on load-use and jr/jalr stalls.
- Accepts branch/jump redirects from ID and flushes the wrong-path instruction.
- Talks to a variable-latency instruction memory with at most one request outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on a bubble (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_if_write_i  input  1  from hazard unit; 0 = hold PC and IF/ID this cycle.
- redirect_i  input  1  branch taken or jump resolved in ID; 1-cycle pulse.
- redirect_target_i  input  32  new fetch PC, word aligned.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
- imem_ready_i  input  1  response valid this cycle; only meaningful while imem_req_o=1.
- imem_rdata_i  input  32  instruction word, valid with imem_ready_i.
- pc_id_o  output  32  IF/ID: PC of the held instruction.
- pc_plus4_id_o  output  32  IF/ID: that PC + 4 (for jal/jalr link).
- instr_id_o  output  32  IF/ID: instruction word.
- valid_id_o  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, pend_pc=0, buf=0.
  - Outputs: pc_id_o=0, pc_plus4_id_o=0, instr_id_o=NOP_INSTR, valid_id_o=0, imem_req_o=0.
  - A reset mid-transaction abandons the outstanding request; memory must drop it.
- States: IDLE, REQ, HOLD, DROP.
  - imem_req_o=1 only in REQ and DROP.
  - imem_addr_o=pc in REQ; imem_addr_o=the stale address (pc register unchanged) in DROP.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ, redirect_i=1 (redirect has priority over all other REQ conditions):
  - If imem_ready_i=1: discard rdata, pc<=redirect_target_i, stay REQ.
  - Else: pend_pc<=redirect_target_i, go to DROP.
  - In both cases IF/ID is flushed (valid_id_o<=0, instr_id_o<=NOP_INSTR), even if pc_if_write_i=0.
- REQ, no redirect, imem_ready_i=1, pc_if_write_i=1:
  - IF/ID<={pc, pc+4, imem_rdata_i, 1}; pc<=pc+4; stay REQ.
  - Back-to-back single-cycle memory gives 1 instruction/cycle.
- REQ, no redirect, imem_ready_i=1, pc_if_write_i=0:
  - buf<=imem_rdata_i; IF/ID holds; PC holds; go to HOLD.
- REQ, no redirect, imem_ready_i=0:
  - If pc_if_write_i=1, IF/ID<=bubble (valid 0, NOP_INSTR, pc fields hold).
  - If pc_if_write_i=0, IF/ID holds.
- HOLD (no request issued):
  - redirect_i=1: discard buf, pc<=target, flush IF/ID, go to REQ.
  - Else pc_if_write_i=1: IF/ID<={pc, pc+4, buf, 1}; pc<=pc+4; go to REQ.
  - Else: remain in HOLD.
- DROP: wait for the stale response.
  - On imem_ready_i=1: discard it, pc<=pend_pc, go to REQ.
  - A further redirect_i in DROP overwrites pend_pc (latest wins).
  - IF/ID shows a bubble while pc_if_write_i=1 and holds while pc_if_write_i=0.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). Bits [1:0] of redirect_target_i are ignored and forced to 0.
- Stalls never alter the in-flight request address; no request is re-issued or lost across a stall.

Test Plan:
- Reset, 1-cycle memory, pc_if_write_i=1: IDLE for 1 cycle, then IF/ID gets PCs 0x0, 0x4, 0x8 on consecutive cycles with valid_id_o=1.
- Stall at PC 0x8 while ready: pc_if_write_i=0 for 2 cycles -> IF/ID holds the 0x4 instruction, imem_req_o=0 in HOLD, then 0x8 enters IF/ID with the buffered word and the next request is 0xC.
- Redirect with ready=1 at PC 0x10, target 0x40: next IF/ID is a bubble (valid 0, instr 0), next imem_addr_o=0x40, no instruction from 0x10 ever reaches ID.
- 3-cycle memory, redirect to 0x80 during a wait at 0x20: DROP holds addr 0x20 until ready, response discarded, then request at 0x80 and IF/ID pc_id_o=0x80 valid.
- Two redirects in DROP (0x100 then 0x200): fetch resumes at 0x200 only.
- Async reset asserted mid-wait: all outputs reach reset values without a clock edge, and fetch restarts at RESET_PC.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0, pc_plus4_id_o=0x0.
